reg_file_ctx: RTL and testbench

Parametrised successor to the accumulator-architecture register file. Provides:
- configurable width and depth;
- two asynchronous read ports with optional write-to-read bypass;
- a hard-wired zero register, a protected flag register and a stack-pointer register with a reset value;
- a shadow bank with a save/restore sequencer for interrupt context switching.

It sits between the decode stage and the ALU/accumulator datapath. The control unit uses it to snapshot and restore architectural state.

---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_file_ctx_seq.sv | 76 +++++++
 rtl/reg_file_ctx.sv | 112 +++++++++++
 tb/tb_reg_file_ctx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and default constants for the context-switching register file
package reg_file_pkg;

    typedef enum logic [1:0] {
        CTX_IDLE    = 2'd0,
        CTX_SAVE    = 2'd1,
        CTX_RESTORE = 2'd2
    } ctx_state_t;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_SP_RESET = 1024;
    localparam int DEF_ACC_IDX  = 15;
    localparam int DEF_FLAG_IDX = 3;
    localparam int DEF_SP_IDX   = 1;

endpackage

// File: rtl/reg_file_ctx_seq.sv
// rtl/reg_file_ctx_seq.sv - save/restore sequencer stepping an index across the register bank
//
// Ports:
//   clock, reset_n          clock and synchronous active-low reset
//   ctx_save, ctx_restore   requests, sampled only while idle (save wins)
//   busy                    a copy is in progress
//   ctx_done                one-cycle pulse after the last copy
//   copy_en                 perform a copy step this cycle
//   copy_dir                0 = RF -> shadow, 1 = shadow -> RF
//   idx                     register index copied this cycle
module reg_file_ctx_seq
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          ctx_save,
    input  logic          ctx_restore,
    output logic          busy,
    output logic          ctx_done,
    output logic          copy_en,
    output logic          copy_dir,
    output logic [AW-1:0] idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    ctx_state_t    state, state_next;
    logic [AW-1:0] idx_q, idx_next;
    logic          done_q, done_next;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= CTX_IDLE;
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            idx_q  <= idx_next;
            done_q <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx_q;
        done_next  = 1'b0;
        case (state)
            CTX_IDLE: begin
                idx_next = '0;
                if (ctx_save) begin
                    state_next = CTX_SAVE;
                end else if (ctx_restore) begin
                    state_next = CTX_RESTORE;
                end
            end
            CTX_SAVE, CTX_RESTORE: begin
                idx_next = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_next = CTX_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = CTX_IDLE;
        endcase
    end

    assign busy     = (state != CTX_IDLE);
    assign copy_en  = (state != CTX_IDLE);
    assign copy_dir = (state == CTX_RESTORE);
    assign ctx_done = done_q;
    assign idx      = idx_q;

endmodule

// File: rtl/reg_file_ctx.sv
// rtl/reg_file_ctx.sv - parametrised register file with protected registers, bypass and shadow bank
//
// Ports:
//   clock, reset_n            clock and synchronous active-low reset
//   ra_a, ra_b / rd_a, rd_b   two combinational read ports
//   wa, write_data, reg_write general write port (R0 and flag register protected)
//   iszero_write, iszero_data flag register write port
//   acc_data                  stored content of the accumulator register
//   ctx_save, ctx_restore     context save/restore requests
//   busy, ctx_done            sequencer status
module reg_file_ctx
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ACC_IDX  = DEF_ACC_IDX,
    parameter int FLAG_IDX = DEF_FLAG_IDX,
    parameter int SP_IDX   = DEF_SP_IDX,
    parameter int SP_RESET = DEF_SP_RESET,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [AW-1:0]     ra_a,
    input  logic [AW-1:0]     ra_b,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    input  logic              iszero_write,
    input  logic [DATA_W-1:0] iszero_data,
    output logic [DATA_W-1:0] acc_data,
    input  logic              ctx_save,
    input  logic              ctx_restore,
    output logic              busy,
    output logic              ctx_done
);

    localparam logic [AW-1:0]     FLAG_A = AW'(FLAG_IDX);
    localparam logic [AW-1:0]     ACC_A  = AW'(ACC_IDX);
    localparam logic [DATA_W-1:0] SP_RST = DATA_W'(SP_RESET);

    logic [DATA_W-1:0] rf [NUM_REGS];
    logic [DATA_W-1:0] sh [NUM_REGS];

    logic          copy_en;
    logic          copy_dir;
    logic [AW-1:0] idx;
    logic          wr_ok;
    logic          flag_ok;

    reg_file_ctx_seq #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_seq (
        .clock       (clock),
        .reset_n     (reset_n),
        .ctx_save    (ctx_save),
        .ctx_restore (ctx_restore),
        .busy        (busy),
        .ctx_done    (ctx_done),
        .copy_en     (copy_en),
        .copy_dir    (copy_dir),
        .idx         (idx)
    );

    // R0 is never written so it reads zero; the flag register only takes iszero writes.
    assign wr_ok   = reg_write && !busy && (wa != '0) && (wa != FLAG_A);
    assign flag_ok = iszero_write && !busy;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= (i == SP_IDX) ? SP_RST : '0;
                sh[i] <= '0;
            end
        end else if (copy_en) begin
            if (copy_dir) begin
                // Index 0 still takes its cycle but R0 is left untouched.
                if (idx != '0) begin
                    rf[idx] <= sh[idx];
                end
            end else begin
                sh[idx] <= rf[idx];
            end
        end else begin
            if (wr_ok) begin
                rf[wa] <= write_data;
            end
            if (flag_ok) begin
                rf[FLAG_A] <= iszero_data;
            end
        end
    end

    // Bypass terms use the already busy-gated accept signals, so no bypass while busy.
    always_comb begin
        rd_a = rf[ra_a];
        rd_b = rf[ra_b];
        if (BYPASS != 0) begin
            if (wr_ok && (wa == ra_a)) rd_a = write_data;
            if (wr_ok && (wa == ra_b)) rd_b = write_data;
            if (flag_ok && (ra_a == FLAG_A)) rd_a = iszero_data;
            if (flag_ok && (ra_b == FLAG_A)) rd_b = iszero_data;
        end
    end

    assign acc_data = rf[ACC_A];

endmodule

// File: tb/tb_reg_file_ctx.sv
// tb/tb_reg_file_ctx.sv - self-checking bench for reg_file_ctx with bypass and non-bypass instances
module tb_reg_file_ctx;

    localparam int N  = 16;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [AW-1:0] ra_a, ra_b, wa;
    logic [DW-1:0] write_data, iszero_data;
    logic          reg_write, iszero_write, ctx_save, ctx_restore;

    logic [DW-1:0] rd_a, rd_b, acc_data;
    logic          busy, ctx_done;
    logic [DW-1:0] rd_a0, rd_b0, acc_data0;
    logic          busy0, ctx_done0;

    always #5 clock = ~clock;

    reg_file_ctx #(.BYPASS(1)) dut (
        .clock(clock), .reset_n(reset_n), .ra_a(ra_a), .ra_b(ra_b),
        .rd_a(rd_a), .rd_b(rd_b), .wa(wa), .write_data(write_data),
        .reg_write(reg_write), .iszero_write(iszero_write), .iszero_data(iszero_data),
        .acc_data(acc_data), .ctx_save(ctx_save), .ctx_restore(ctx_restore),
        .busy(busy), .ctx_done(ctx_done)
    );

    reg_file_ctx #(.BYPASS(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .ra_a(ra_a), .ra_b(ra_b),
        .rd_a(rd_a0), .rd_b(rd_b0), .wa(wa), .write_data(write_data),
        .reg_write(reg_write), .iszero_write(iszero_write), .iszero_data(iszero_data),
        .acc_data(acc_data0), .ctx_save(ctx_save), .ctx_restore(ctx_restore),
        .busy(busy0), .ctx_done(ctx_done0)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register contents, shadow contents, and how many copy cycles remain.
    logic [DW-1:0] m_rf [N];
    logic [DW-1:0] m_sh [N];
    int            m_left    = 0;
    bit            m_restore = 1'b0;
    bit            m_done    = 1'b0;
    bit            m_valid   = 1'b0;

    always @(posedge clock) begin
        bit nd;
        int j;
        nd = 1'b0;
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                m_rf[i] = (i == 1) ? 16'd1024 : 16'd0;
                m_sh[i] = 16'd0;
            end
            m_left  = 0;
            m_done  = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_left > 0) begin
                j = N - m_left;
                if (m_restore) begin
                    if (j != 0) m_rf[j] = m_sh[j];
                end else begin
                    m_sh[j] = m_rf[j];
                end
                m_left = m_left - 1;
                nd = (m_left == 0);
            end else begin
                if (reg_write && wa != 0 && wa != 3) m_rf[wa] = write_data;
                if (iszero_write) m_rf[3] = iszero_data;
                if (ctx_save) begin
                    m_left = N;
                    m_restore = 1'b0;
                end else if (ctx_restore) begin
                    m_left = N;
                    m_restore = 1'b1;
                end
            end
            m_done = nd;
        end
    end

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] ra, input bit byp);
        logic [DW-1:0] v;
        v = m_rf[ra];
        if (byp && m_left == 0) begin
            if (reg_write && wa == ra && wa != 0 && wa != 3) v = write_data;
            if (iszero_write && ra == 3) v = iszero_data;
        end
        return v;
    endfunction

    always @(negedge clock) begin
        if (m_valid) begin
            chk("rd_a",      rd_a,      m_read(ra_a, 1'b1));
            chk("rd_b",      rd_b,      m_read(ra_b, 1'b1));
            chk("rd_a_nb",   rd_a0,     m_read(ra_a, 1'b0));
            chk("rd_b_nb",   rd_b0,     m_read(ra_b, 1'b0));
            chk("acc",       acc_data,  m_rf[15]);
            chk("acc_nb",    acc_data0, m_rf[15]);
            chk("busy",      busy,      (m_left > 0));
            chk("busy_nb",   busy0,     (m_left > 0));
            chk("ctx_done",  ctx_done,  m_done);
            chk("ctx_done_nb", ctx_done0, m_done);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        reg_write = 1'b1; wa = a; write_data = d;
        tick();
        reg_write = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
    endtask

    int cnt;

    initial begin
        reset_n = 1'b0; ra_a = '0; ra_b = '0; wa = '0; write_data = '0;
        reg_write = 1'b0; iszero_write = 1'b0; iszero_data = '0;
        ctx_save = 1'b0; ctx_restore = 1'b0;
        tick();
        reset_n = 1'b1;

        // Reset values
        for (int i = 0; i < N; i++) begin
            ra_a = 4'(i); ra_b = 4'(i);
            #1;
            chk("rst_rd_a", rd_a, (i == 1) ? 32'd1024 : 32'd0);
            chk("rst_rd_b", rd_b0, (i == 1) ? 32'd1024 : 32'd0);
        end
        chk("rst_busy", busy, 0);
        chk("rst_done", ctx_done, 0);

        // Write protection
        wr(4'd0, 16'hBEEF);
        wr(4'd3, 16'hBEEF);
        ra_a = 4'd0; ra_b = 4'd3; #1;
        chk("r0_prot", rd_a, 0);
        chk("flag_prot", rd_b, 0);
        iszero_write = 1'b1; iszero_data = 16'h0001;
        tick();
        iszero_write = 1'b0;
        #1;
        chk("flag_write", rd_b, 16'h0001);
        wr(4'd15, 16'h1234);
        #1;
        chk("acc_write", acc_data, 16'h1234);

        // Bypass
        ra_a = 4'd5; reg_write = 1'b1; wa = 4'd5; write_data = 16'hA5A5;
        #1;
        chk("bypass_on", rd_a, 16'hA5A5);
        chk("bypass_off", rd_a0, 16'h0000);
        tick();
        reg_write = 1'b0;

        // Save with blocked write and ignored restore
        wr(4'd2, 16'h1111);
        wr(4'd15, 16'h2222);
        ctx_save = 1'b1;
        tick();
        ctx_save = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            if (cnt == 3) begin
                reg_write = 1'b1; wa = 4'd4; write_data = 16'h7777; ctx_restore = 1'b1;
            end else begin
                reg_write = 1'b0; ctx_restore = 1'b0;
            end
            tick();
        end
        chk("save_busy_len", cnt, 16);
        chk("save_done", ctx_done, 1);
        tick();
        chk("no_queued_restore", busy, 0);
        chk("done_one_cycle", ctx_done, 0);
        ra_a = 4'd4; #1;
        chk("busy_write_dropped", rd_a, 0);

        // Restore round trip
        wr(4'd2, 16'h0000);
        wr(4'd15, 16'h0000);
        ctx_restore = 1'b1;
        tick();
        ctx_restore = 1'b0;
        wait_idle(cnt);
        chk("restore_busy_len", cnt, 16);
        tick();
        ra_a = 4'd2; ra_b = 4'd0; #1;
        chk("restore_r2", rd_a, 16'h1111);
        chk("restore_r0", rd_b, 0);
        chk("restore_r15", acc_data, 16'h2222);

        // Simultaneous save+restore: save must win
        wr(4'd2, 16'h3333);
        ctx_save = 1'b1; ctx_restore = 1'b1;
        tick();
        ctx_save = 1'b0; ctx_restore = 1'b0;
        wait_idle(cnt);
        tick();
        ra_a = 4'd2; #1;
        chk("save_wins", rd_a, 16'h3333);

        // Reset in the middle of a restore
        ctx_restore = 1'b1;
        tick();
        ctx_restore = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        ra_a = 4'd1; ra_b = 4'd2; #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_sp", rd_a, 1024);
        chk("midrst_r2", rd_b, 0);
        ctx_restore = 1'b1;
        tick();
        ctx_restore = 1'b0;
        wait_idle(cnt);
        tick();
        #1;
        chk("zero_restore_sp", rd_a, 0);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            ra_a         = 4'($urandom_range(0, 15));
            ra_b         = 4'($urandom_range(0, 15));
            wa           = 4'($urandom_range(0, 15));
            write_data   = 16'($urandom);
            iszero_data  = 16'($urandom);
            reg_write    = ($urandom_range(0, 2) != 0);
            iszero_write = ($urandom_range(0, 3) == 0);
            ctx_save     = ($urandom_range(0, 24) == 0);
            ctx_restore  = ($urandom_range(0, 24) == 0);
            reset_n      = ($urandom_range(0, 299) != 0);
            tick();
        end
        reset_n = 1'b1; reg_write = 1'b0; iszero_write = 1'b0;
        ctx_save = 1'b0; ctx_restore = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
